case_2_sdiv_13s_5s_11_seq: RTL and testbench
============================================

Name: case_2_sdiv_13s_5s_11_seq

Overview:
- Multi-cycle signed integer divider. It is the inverse operator of the 11s x 5s -> 13 signed multiplier core.
- Computes quotient and remainder of a 13-bit signed dividend by a 5-bit signed divisor, with C truncate-toward-zero semantics.
- Radix-2 restoring iteration on magnitudes, then sign fix-up.
- Sits in the datapath as an HLS-style operator core with valid/ready handshakes on both sides.

Parameters:
- din0_WIDTH, 13, dividend width (signed).
- din1_WIDTH, 5, divisor width (signed).
- quot_WIDTH, 11, quotient output width (signed, truncated from the full result).

Ports:
- ap_clk  in  1  clock, rising-edge.
- ap_rst  in  1  asynchronous active-high reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  divider can accept operands.
- din0  in  din0_WIDTH  dividend, signed.
- din1  in  din1_WIDTH  divisor, signed.
- out_valid  out  1  results valid.
- out_ready  in  1  consumer accepts results.
- quot  out  quot_WIDTH  quotient, signed, low quot_WIDTH bits of the full quotient.
- rem  out  din1_WIDTH  remainder, signed.
- div_by_zero  out  1  set with results when din1 was 0.

Behaviour:
- Reset (async, any time, including mid-division) forces:
  - state IDLE, in_ready=1, out_valid=0;
  - quot=0, rem=0, div_by_zero=0;
  - iteration counter=0, all internal regs cleared.
- Reset release is sampled on the next rising edge.
- States:
  - IDLE: in_ready=1. in_valid&in_ready at an edge latches |din0|, |din1|, both sign bits, and a zero-divisor flag, then goes to CALC.
  - CALC: one quotient bit per cycle, MSB first, for din0_WIDTH (13) cycles. The partial remainder is din1_WIDTH+1 bits wide. Shift in the next dividend bit; trial-subtract |divisor|; if non-negative keep the difference and set the quotient bit to 1, else restore and set it to 0. On the last iteration go to FIX.
  - FIX: 1 cycle.
    - Quotient is negated if sign(din0) XOR sign(din1); remainder is negated if sign(din0).
    - Quotient is truncated to quot_WIDTH bits and loaded into quot/rem/div_by_zero. Go to OUT.
  - OUT: out_valid=1, outputs stable. On out_ready=1 at an edge go to IDLE.
- in_ready=1 only in IDLE. in_valid in any other state is ignored (no queuing).
- Latency: with the accepting edge counted as edge 1, out_valid rises after edge din0_WIDTH+2 (15 with defaults). Throughput is 1 result per 16 cycles when out_ready is held high.
- Backpressure: out_valid stays high and quot/rem/div_by_zero hold indefinitely while out_ready=0.
- Outputs keep their last value after the handshake until the next FIX. out_valid drops the cycle after the handshake.
- Arithmetic:
  - Dividend magnitude is up to 4096 (13 unsigned bits); divisor magnitude is up to 16.
  - |rem| < |divisor|, so rem always fits din1_WIDTH signed.
  - Quotient overflow (|q| > 1023) wraps silently by truncation, matching HLS operator semantics. Example: -4096/-1 -> quot=0.
- Divide by zero (din1=0): same latency; quot=all ones (-1), rem=0, div_by_zero=1. The CALC iterations still run and their result is discarded.
- Dividend 0: quot=0, rem=0 (no negative zero issue, since negating 0 gives 0).

Test Plan:
- Reset then idle: in_ready=1, out_valid=0, all outputs 0. din0=100, din1=7 accepted -> out_valid after 15 edges, quot=14, rem=2, div_by_zero=0.
- Sign combinations:
  - -100/7 -> quot=-14 (0x7F2), rem=-2 (0x1E).
  - 100/-7 -> quot=-14, rem=2.
  - -100/-7 -> quot=14, rem=-2.
- Truncation/overflow:
  - 4095/1 -> quot=0x7FF (-1), rem=0.
  - -4096/-1 -> quot=0, rem=0.
  - 1000/3 -> quot=333, rem=1.
- Divide by zero: 50/0 -> after 15 edges quot=0x7FF, rem=0, div_by_zero=1. A following 9/4 gives quot=2, rem=1, div_by_zero=0.
- Backpressure and busy: out_ready=0 for 20 cycles after out_valid -> outputs held constant. in_valid pulses during CALC/OUT are ignored (in_ready=0). Releasing out_ready -> IDLE next cycle; the next operand is accepted.
- Async reset asserted at CALC iteration 6 between edges -> in_ready=1, out_valid=0, outputs 0 immediately. No spurious result after release. A new 100/7 completes correctly.

Source files
------------

// File: rtl/case_2_sdiv_13s_5s_11_seq.sv
// Multi-cycle signed divider (13s / 5s -> 11s quotient, 5s remainder), truncating toward zero.
// Radix-2 restoring iteration on magnitudes followed by a one-cycle sign fix-up.
module case_2_sdiv_13s_5s_11_seq #(
   parameter int din0_WIDTH = 13,
   parameter int din1_WIDTH = 5,
   parameter int quot_WIDTH = 11
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [din0_WIDTH-1:0] din0,
   input  logic [din1_WIDTH-1:0] din1,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [quot_WIDTH-1:0] quot,
   output logic [din1_WIDTH-1:0] rem,
   output logic                  div_by_zero
);

   localparam int CNT_W = $clog2(din0_WIDTH);

   typedef enum logic [1:0] {st_idle, st_calc, st_fix, st_out} state_t;

   state_t                state;
   logic [CNT_W-1:0]      cnt;
   // Dividend magnitude shifts out at the MSB while quotient bits shift in at the LSB.
   logic [din0_WIDTH-1:0] dq;
   logic [din1_WIDTH-1:0] dvs;
   logic [din1_WIDTH:0]   prem;
   logic                  s0, s1, dz;

   logic [din0_WIDTH-1:0] a_mag;
   logic [din1_WIDTH-1:0] b_mag;
   logic [din1_WIDTH+1:0] shifted;
   logic                  ge;
   logic [din1_WIDTH:0]   diff;
   logic [quot_WIDTH-1:0] q_lo, q_fix;
   logic [din1_WIDTH-1:0] r_fix;

   always_comb begin
      a_mag   = din0[din0_WIDTH-1] ? -din0 : din0;
      b_mag   = din1[din1_WIDTH-1] ? -din1 : din1;
      shifted = {prem, dq[din0_WIDTH-1]};
      ge      = shifted >= {2'b00, dvs};
      // Only used when ge is set, so the result always fits without the top bit.
      diff    = shifted[din1_WIDTH:0] - {1'b0, dvs};
      q_lo    = dq[quot_WIDTH-1:0];
      q_fix   = (s0 ^ s1) ? -q_lo : q_lo;
      r_fix   = s0 ? -prem[din1_WIDTH-1:0] : prem[din1_WIDTH-1:0];
   end

   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         state       <= st_idle;
         cnt         <= '0;
         dq          <= '0;
         dvs         <= '0;
         prem        <= '0;
         s0          <= 1'b0;
         s1          <= 1'b0;
         dz          <= 1'b0;
         in_ready    <= 1'b1;
         out_valid   <= 1'b0;
         quot        <= '0;
         rem         <= '0;
         div_by_zero <= 1'b0;
      end else begin
         unique case (state)
            st_idle: begin
               if (in_valid) begin
                  dq       <= a_mag;
                  dvs      <= b_mag;
                  s0       <= din0[din0_WIDTH-1];
                  s1       <= din1[din1_WIDTH-1];
                  dz       <= (din1 == '0);
                  prem     <= '0;
                  cnt      <= '0;
                  in_ready <= 1'b0;
                  state    <= st_calc;
               end
            end
            st_calc: begin
               dq   <= {dq[din0_WIDTH-2:0], ge};
               prem <= ge ? diff : shifted[din1_WIDTH:0];
               if (cnt == CNT_W'(din0_WIDTH - 1)) begin
                  cnt   <= '0;
                  state <= st_fix;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            st_fix: begin
               // A zero divisor lets every trial subtract succeed; that result is discarded.
               if (dz) begin
                  quot        <= '1;
                  rem         <= '0;
                  div_by_zero <= 1'b1;
               end else begin
                  quot        <= q_fix;
                  rem         <= r_fix;
                  div_by_zero <= 1'b0;
               end
               out_valid <= 1'b1;
               state     <= st_out;
            end
            st_out: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= st_idle;
               end
            end
            default: state <= st_idle;
         endcase
      end
   end

endmodule

// File: tb/tb_case_2_sdiv_13s_5s_11_seq.sv
// Directed bench for the sequential signed divider: scoreboard of expected results checked
// against the DUT outputs, plus latency, backpressure, busy and async-reset checks.
module tb_case_2_sdiv_13s_5s_11_seq;

   logic        ap_clk = 1'b0;
   logic        ap_rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [12:0] din0 = '0;
   logic [4:0]  din1 = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [10:0] quot;
   logic [4:0]  rem;
   logic        div_by_zero;

   typedef struct packed {
      logic [10:0] q;
      logic [4:0]  r;
      logic        z;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   passed = 0;

   always #5 ap_clk = ~ap_clk;

   case_2_sdiv_13s_5s_11_seq dut (
      .ap_clk      (ap_clk),
      .ap_rst      (ap_rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .din0        (din0),
      .din1        (din1),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quot        (quot),
      .rem         (rem),
      .div_by_zero (div_by_zero)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Push the C-semantics result, then present the operands for exactly one edge.
   task automatic send(input int a, input int b);
      exp_t e;
      if (b == 0) begin
         e.q = '1;
         e.r = '0;
         e.z = 1'b1;
      end else begin
         e.q = 11'(a / b);
         e.r = 5'(a % b);
         e.z = 1'b0;
      end
      sb.push_back(e);
      @(negedge ap_clk);
      check($sformatf("in_ready_before_%0d_%0d", a, b), 32'(in_ready), 32'd1);
      din0     = 13'(a);
      din1     = 5'(b);
      in_valid = 1'b1;
      @(posedge ap_clk);
      #1 in_valid = 1'b0;
   endtask

   // Wait for the result, compare it, optionally stall and poke in_valid while busy.
   task automatic collect(input string tag, input int hold, input bit poke);
      int   n = 1;
      int   busy_ok = 0;
      int   busy_n = 0;
      int   held = 0;
      exp_t e;
      exp_t snap;
      while (!out_valid && n < 40) begin
         if (poke) begin
            in_valid = 1'b1;
            din0     = 13'd77;
            din1     = 5'd3;
         end
         @(posedge ap_clk);
         #1;
         n++;
         if (poke && !out_valid) begin
            busy_n++;
            if (!in_ready) busy_ok++;
         end
      end
      in_valid = 1'b0;
      check({tag, "_latency"}, 32'(n), 32'd15);
      if (sb.size() != 0) e = sb.pop_front();
      else e = '0;
      check({tag, "_quot"}, 32'(quot), 32'(e.q));
      check({tag, "_rem"}, 32'(rem), 32'(e.r));
      check({tag, "_dbz"}, 32'(div_by_zero), 32'(e.z));
      if (poke) check({tag, "_busy_in_ready"}, 32'(busy_ok), 32'(busy_n));
      if (hold > 0) begin
         out_ready = 1'b0;
         snap = {quot, rem, div_by_zero};
         for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            din0     = 13'd5;
            din1     = 5'd1;
            @(posedge ap_clk);
            #1;
            if (out_valid && !in_ready && ({quot, rem, div_by_zero} === snap)) held++;
         end
         in_valid = 1'b0;
         check({tag, "_held"}, 32'(held), 32'(hold));
         out_ready = 1'b1;
      end
      @(posedge ap_clk);
      #1;
      check({tag, "_out_valid_drop"}, 32'(out_valid), 32'd0);
      check({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      int spurious;
      repeat (2) @(posedge ap_clk);
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_outputs", 32'({quot, rem, div_by_zero}), 32'd0);
      @(negedge ap_clk);
      ap_rst = 1'b0;

      send(100, 7);     collect("p100_p7", 0, 1'b0);
      send(-100, 7);    collect("m100_p7", 0, 1'b0);
      send(100, -7);    collect("p100_m7", 0, 1'b0);
      send(-100, -7);   collect("m100_m7", 0, 1'b0);
      send(4095, 1);    collect("p4095_p1", 0, 1'b0);
      send(-4096, -1);  collect("m4096_m1", 0, 1'b0);
      send(1000, 3);    collect("p1000_p3", 0, 1'b0);
      send(50, 0);      collect("p50_zero", 0, 1'b0);
      send(9, 4);       collect("p9_p4", 0, 1'b0);
      send(0, -5);      collect("zero_m5", 0, 1'b0);
      send(-4096, -16); collect("m4096_m16", 0, 1'b0);
      send(-1234, 11);  collect("m1234_p11", 20, 1'b1);
      send(37, -6);     collect("p37_m6", 0, 1'b0);

      // Async reset in the middle of CALC, between clock edges.
      send(100, 7);
      repeat (6) @(posedge ap_clk);
      #2 ap_rst = 1'b1;
      #1;
      check("midrst_in_ready", 32'(in_ready), 32'd1);
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_outputs", 32'({quot, rem, div_by_zero}), 32'd0);
      void'(sb.pop_front());
      @(negedge ap_clk);
      ap_rst = 1'b0;
      spurious = 0;
      repeat (20) begin
         @(posedge ap_clk);
         #1;
         if (out_valid) spurious++;
      end
      check("midrst_no_spurious", 32'(spurious), 32'd0);
      send(100, 7);     collect("after_rst", 0, 1'b0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
